// File: rtl/mod_updown_counter_if.sv
// Bus bundle for mod_updown_counter: count controls, load data and the
// counter's q/tc/ovf results. clk and clear stay as plain module ports.
interface mod_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             ovf_clr;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up, load, d, ovf_clr,
    input  q, tc, ovf
  );

  modport slave (
    input  en, up, load, d, ovf_clr,
    output q, tc, ovf
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Synchronous modulo up/down counter with load, cascadable tc and sticky ovf.
// Define COUNTER_SATURATE_EN to hold at the terminal value instead of wrapping.
module mod_updown_counter #(
  parameter int unsigned     WIDTH  = 4,
  parameter longint unsigned MODULO = 16
) (
  input  logic                 clk,
  input  logic                 clear,
  mod_updown_counter_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 1..32");
  end
  if (MODULO < 2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_modulo
    $error("mod_updown_counter: MODULO must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 64'd1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;
  logic             ovf_flag;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] step_val;
  logic             at_top;
  logic             at_bot;
  logic             wrap;

  always_comb begin
    at_top   = (count == MAX);
    at_bot   = (count == '0);
    load_val = (bus.d > MAX) ? MAX : bus.d;
    // A wrap edge is exactly one where tc is high, so tc doubles as the ovf set term.
    wrap     = bus.en & ~bus.load & ~clear & (bus.up ? at_top : at_bot);
    step_val = count;
    if (bus.up) begin
`ifdef COUNTER_SATURATE_EN
      step_val = at_top ? MAX : count + ONE;
`else
      step_val = at_top ? '0 : count + ONE;
`endif
    end else begin
`ifdef COUNTER_SATURATE_EN
      step_val = at_bot ? '0 : count - ONE;
`else
      step_val = at_bot ? MAX : count - ONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count    <= '0;
      ovf_flag <= 1'b0;
    end else begin
      if (bus.load)
        count <= load_val;
      else if (bus.en)
        count <= step_val;

      if (wrap)
        ovf_flag <= 1'b1;
      else if (bus.ovf_clr)
        ovf_flag <= 1'b0;
    end
  end

  assign bus.q   = count;
  assign bus.ovf = ovf_flag;
  assign bus.tc  = wrap;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomized self-checking bench for mod_updown_counter (WIDTH=4, MODULO=10),
// including a two-stage cascade; follows COUNTER_SATURATE_EN when defined.
module tb_mod_updown_counter;

  localparam int unsigned     W    = 4;
  localparam longint unsigned M    = 10;
  localparam int              MAXV = 9;
`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic clear;
  logic cclear;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mod_updown_counter_if #(.WIDTH(W)) m ();
  mod_updown_counter_if #(.WIDTH(W)) lo ();
  mod_updown_counter_if #(.WIDTH(W)) hi ();

  mod_updown_counter #(.WIDTH(W), .MODULO(M)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (m)
  );

  mod_updown_counter #(.WIDTH(W), .MODULO(M)) u_lo (
    .clk   (clk),
    .clear (cclear),
    .bus   (lo)
  );

  mod_updown_counter #(.WIDTH(W), .MODULO(M)) u_hi (
    .clk   (clk),
    .clear (cclear),
    .bus   (hi)
  );

  assign hi.en = lo.tc;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    clear     = 1'b0;
    m.en      = 1'b0;
    m.up      = 1'b1;
    m.load    = 1'b0;
    m.d       = '0;
    m.ovf_clr = 1'b0;
  endtask

  // Expected next count for one enabled step, from the modulo/saturate rules.
  function automatic int next_count(int cur, bit dir_up);
    if (dir_up) begin
      if (cur == MAXV) return SAT ? MAXV : 0;
      return cur + 1;
    end
    if (cur == 0) return SAT ? 0 : MAXV;
    return cur - 1;
  endfunction

  task automatic test_reset();
    idle();
    m.load = 1'b1; m.d = 4'd9;
    tick();
    m.load = 1'b0; m.en = 1'b1; m.up = 1'b1;
    tick();
    clear = 1'b1; m.load = 1'b1; m.d = 4'd5; m.up = 1'b0; m.en = 1'b1;
    #1;
    n_tests++;
    if (m.ovf !== 1'b1) begin
      n_fail++; $display("FAIL reset_between_edges ovf=%b expected 1", m.ovf);
    end
    n_tests++;
    if (m.tc !== 1'b0) begin
      n_fail++; $display("FAIL reset_tc tc=%b expected 0", m.tc);
    end
    tick();
    n_tests++;
    if (m.q !== 4'd0) begin
      n_fail++; $display("FAIL reset_q q=%0d expected 0", m.q);
    end
    n_tests++;
    if (m.ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_ovf ovf=%b expected 0", m.ovf);
    end
    idle();
  endtask

  task automatic test_up_wrap();
    int  exp_q = 0;
    bit  exp_ovf = 1'b0;
    bit  exp_tc;
    idle();
    m.en = 1'b1; m.up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      #1;
      exp_tc = (exp_q == MAXV);
      n_tests++;
      if (m.tc !== exp_tc) begin
        n_fail++; $display("FAIL up_wrap_tc edge=%0d tc=%b expected %b", i, m.tc, exp_tc);
      end
      tick();
      if (exp_tc) exp_ovf = 1'b1;
      exp_q = next_count(exp_q, 1'b1);
      n_tests++;
      if (m.q !== 4'(exp_q) || m.ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL up_wrap_q edge=%0d q=%0d ovf=%b expected q=%0d ovf=%b",
                 i, m.q, m.ovf, exp_q, exp_ovf);
      end
    end
    idle();
  endtask

  task automatic test_down_race();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m.en = 1'b1; m.up = 1'b0; m.ovf_clr = 1'b1;
    #1;
    n_tests++;
    if (m.tc !== 1'b1) begin
      n_fail++; $display("FAIL down_tc tc=%b expected 1", m.tc);
    end
    tick();
    n_tests++;
    if (m.q !== 4'(SAT ? 0 : MAXV) || m.ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL down_race q=%0d ovf=%b expected q=%0d ovf=1", m.q, m.ovf, SAT ? 0 : MAXV);
    end
    m.en = 1'b0;
    tick();
    n_tests++;
    if (m.q !== 4'(SAT ? 0 : MAXV) || m.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear q=%0d ovf=%b expected q=%0d ovf=0", m.q, m.ovf, SAT ? 0 : MAXV);
    end
    idle();
  endtask

  task automatic test_load();
    logic [W-1:0] dv [4] = '{4'd7, 4'd12, 4'd9, 4'd15};
    int           ev [4] = '{7, 9, 9, 9};
    idle();
    m.en = 1'b1; m.up = 1'b1; m.load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m.d = dv[i];
      #1;
      n_tests++;
      if (m.tc !== 1'b0) begin
        n_fail++; $display("FAIL load_tc d=%0d tc=%b expected 0", dv[i], m.tc);
      end
      tick();
      n_tests++;
      if (m.q !== 4'(ev[i]) || m.ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL load d=%0d q=%0d ovf=%b expected q=%0d ovf=0", dv[i], m.q, m.ovf, ev[i]);
      end
    end
    clear = 1'b1; m.d = 4'd7;
    tick();
    n_tests++;
    if (m.q !== 4'd0) begin
      n_fail++; $display("FAIL load_with_clear q=%0d expected 0", m.q);
    end
    idle();
  endtask

  task automatic test_cascade();
    int steps_hi = 0;
    int lo_q = 0;
    int hi_q = 0;
    bit hi_ovf = 1'b0;
    cclear = 1'b1;
    lo.en = 1'b0; lo.up = 1'b1; lo.load = 1'b0; lo.d = '0; lo.ovf_clr = 1'b0;
    hi.up = 1'b1; hi.load = 1'b0; hi.d = '0; hi.ovf_clr = 1'b0;
    tick();
    cclear = 1'b0;
    lo.en = 1'b1;
    // Reference: low stage advances every edge; high stage advances whenever low sits at 9.
    for (int i = 0; i < 25; i++) begin
      if (lo_q == MAXV) begin
        if (hi_q == MAXV) hi_ovf = 1'b1;
        hi_q = next_count(hi_q, 1'b1);
        steps_hi++;
      end
      lo_q = next_count(lo_q, 1'b1);
      tick();
    end
    n_tests++;
    if (hi.q !== 4'(hi_q) || lo.q !== 4'(lo_q) || hi.ovf !== hi_ovf) begin
      n_fail++;
      $display("FAIL cascade hi=%0d lo=%0d hi_ovf=%b expected hi=%0d lo=%0d hi_ovf=%b",
               hi.q, lo.q, hi.ovf, hi_q, lo_q, hi_ovf);
    end
    n_tests++;
    if (!SAT && (hi.q !== 4'd2 || lo.q !== 4'd5 || steps_hi != 2)) begin
      n_fail++; $display("FAIL cascade_plan hi=%0d lo=%0d expected hi=2 lo=5", hi.q, lo.q);
    end
    lo.en = 1'b0;
  endtask

`ifdef COUNTER_SATURATE_EN
  task automatic test_saturate();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m.en = 1'b1; m.up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_tests++;
      if (m.q !== 4'((i > MAXV) ? MAXV : i) || m.ovf !== (i >= 10)) begin
        n_fail++;
        $display("FAIL sat_up edge=%0d q=%0d ovf=%b", i, m.q, m.ovf);
      end
    end
    m.up = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_tests++;
      if (m.q !== 4'((MAXV - i < 0) ? 0 : MAXV - i)) begin
        n_fail++;
        $display("FAIL sat_down edge=%0d q=%0d expected %0d", i, m.q, (MAXV - i < 0) ? 0 : MAXV - i);
      end
    end
    idle();
  endtask
`endif

  task automatic test_random();
    int mq = 0;
    bit mov = 1'b0;
    bit exp_tc;
    int dv;
    idle();
    clear = 1'b1;
    tick();
    for (int i = 0; i < 400; i++) begin
      clear     = ($urandom_range(0, 31) == 0);
      m.load    = ($urandom_range(0, 7) == 0);
      m.ovf_clr = ($urandom_range(0, 7) == 0);
      m.en      = ($urandom_range(0, 3) != 0);
      m.up      = ($urandom_range(0, 2) != 0);
      dv        = $urandom_range(0, 15);
      m.d       = 4'(dv);
      #1;
      exp_tc = m.en && !m.load && !clear && (m.up ? (mq == MAXV) : (mq == 0));
      n_tests++;
      if (m.tc !== exp_tc) begin
        n_fail++; $display("FAIL rand_tc cyc=%0d tc=%b expected %b", i, m.tc, exp_tc);
      end
      tick();
      if (clear) begin
        mq = 0; mov = 1'b0;
      end else begin
        if (m.load) mq = (dv > MAXV) ? MAXV : dv;
        else if (m.en) mq = next_count(mq, m.up);
        if (exp_tc) mov = 1'b1;
        else if (m.ovf_clr) mov = 1'b0;
      end
      n_tests++;
      if (m.q !== 4'(mq) || m.ovf !== mov) begin
        n_fail++;
        $display("FAIL rand_state cyc=%0d q=%0d ovf=%b expected q=%0d ovf=%b", i, m.q, m.ovf, mq, mov);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    cclear = 1'b1;
    lo.en = 1'b0; lo.up = 1'b1; lo.load = 1'b0; lo.d = '0; lo.ovf_clr = 1'b0;
    hi.up = 1'b1; hi.load = 1'b0; hi.d = '0; hi.ovf_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_up_wrap();
    test_down_race();
    test_load();
    test_cascade();
`ifdef COUNTER_SATURATE_EN
    test_saturate();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous successor to the 4-bit ripple counter.
- All bits update on the same clk edge. Configurable width and modulus.
- Supports up/down counting, count enable, parallel load, a cascadable terminal-count output and a sticky overflow flag.
- Used as a timebase/event counter; stages chain by wiring tc to the next stage's en.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- MODULO, 16, count range 0..MODULO-1; legal range 2..2**WIDTH; out-of-range values are a static error (elaboration-time check).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clear  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 counts up, 0 counts down; sampled each cycle.
- load  input  1  parallel load strobe.
- d  input  WIDTH  load value.
- ovf_clr  input  1  clears the sticky ovf flag.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational).
- ovf  output  1  sticky wrap indicator (registered).

Behaviour:
- Reset: clear high at a rising edge gives q=0 and ovf=0 on the next cycle. tc follows from q and the other inputs. Reset is synchronous only; clear has no effect between edges.
- Reset mid-count overrides everything: load, en and ovf set are all ignored in that cycle.
- Priority per edge: clear > load > en > hold.
- Load:
  - load=1 gives q <= d when d <= MODULO-1; otherwise q <= MODULO-1 (clamped).
  - Load does not set ovf and ignores en and up.
- Count up (en=1, up=1): q <= q+1. At q == MODULO-1 it wraps to q <= 0 and sets ovf.
- Count down (en=1, up=0): q <= q-1. At q == 0 it wraps to q <= MODULO-1 and sets ovf.
- Hold: en=0 keeps q.
- Latency: q reflects an action one cycle after the edge that samples it.
- tc = en & ~load & ~clear & ((up & q==MODULO-1) | (~up & q==0)).
  - tc is high exactly in the cycle whose edge causes a wrap.
  - Cascading tc into the next stage's en gives one next-stage step per wrap.
- ovf set/clear:
  - Set on any wrap edge.
  - Cleared by ovf_clr=1.
  - If a wrap and ovf_clr occur on the same edge, set wins and ovf=1.
  - clear always forces ovf=0.
- A direction change takes effect on the same edge it is sampled; there is no pipeline to flush.
- With MODULO == 2**WIDTH, wrap is natural binary overflow.
- Arithmetic uses WIDTH bits. Internal compares use MODULO-1 sized to WIDTH bits.
- No combinational path exists from any input to q or ovf.

Optional Feature:
- Macro: COUNTER_SATURATE_EN.
- Defined:
  - At the terminal value, q holds instead of wrapping: up stays at MODULO-1, down stays at 0.
  - ovf is still set on each attempted step past the terminal value.
  - tc is unchanged; it is still asserted while en is high at the terminal value in the counting direction.
  - Load clamping is unchanged.
- Not defined: wrap behaviour as described above.

Test Plan (WIDTH=4, MODULO=10 unless stated):
- Reset: clear=1 for 1 edge with q arbitrary and load=1, d=5 -> q=0, ovf=0; load ignored.
- Up wrap: en=1, up=1 for 12 edges from 0 -> q=1..9,0,1,2; tc high only in the cycle q=9; ovf=1 from the edge after that cycle.
- Down wrap and ovf race: up=0 from q=0 with ovf_clr=1 on the same edge -> q=9, ovf=1. Next edge with ovf_clr=1, en=0 -> ovf=0, q=9.
- Load: d=7 with load=1, en=1 -> q=7 (no step). d=12 -> q=9 (clamped). load together with clear -> q=0.
- Cascade: two instances (MODULO=10), low stage's tc drives high stage's en, 25 edges up from 0 -> high q=2, low q=5, high ovf=0.
- COUNTER_SATURATE_EN defined: 12 up edges from 0 -> q stops at 9, ovf=1 after edge 10; then down 12 edges -> q stops at 0.
